// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flop, one bit per clock, LSB first.
// Latency: WIDTH+1 cycles from the accepting start edge to done; busy covers the WIDTH shift cycles.
// Backpressure: none; start is only accepted in IDLE or DONE (back-to-back) and is ignored while busy.
//
// Ports:
//   clk, reset         - single clock, synchronous active-high reset
//   start, sub, A, B,  - operation request; sub=0 -> A+B+Cin, sub=1 -> A-B (Cin ignored)
//   Cin
//   busy, done         - busy while shifting; done is a one-cycle result-valid pulse
//   Sum, Carry_out,    - result and flags, held until the next operation completes
//   Overflow
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry_out,
  output logic             Overflow
);

  // Counter holds 0..WIDTH so it never wraps during an operation.
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  // Partial result: only WIDTH-1 bits are needed because the final bit goes
  // straight into Sum on the last shift edge.
  logic [WIDTH-2:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             s_bit;
  logic             c_next;
  logic             last_bit;
  logic             load_op;
  logic [WIDTH-1:0] res_shift;

  // The single full-adder cell.
  assign s_bit  = a_q[0] ^ b_q[0] ^ carry_q;
  assign c_next = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

  assign last_bit  = (cnt_q == CW'(WIDTH - 1));
  assign res_shift = {s_bit, res_q};
  assign load_op   = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    busy    = 1'b0;
    done    = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_IDLE;
      end
      S_SHIFT: begin
        busy    = 1'b1;
        res_d   = res_shift[WIDTH-1:1];
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = c_next;
        cnt_d   = cnt_q + CW'(1);
        if (last_bit) begin
          state_d = S_DONE;
          sum_d   = res_shift;
          cout_d  = c_next;
          // carry_q is the carry into the MSB on this edge.
          ovf_d   = carry_q ^ c_next;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Subtraction is A + ~B + 1, so B is inverted at capture and the carry preset.
    if (load_op) begin
      state_d = S_SHIFT;
      a_d     = A;
      b_d     = sub ? ~B : B;
      carry_d = sub ? 1'b1 : Cin;
      cnt_d   = '0;
      res_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Sum       = sum_q;
  assign Carry_out = cout_q;
  assign Overflow  = ovf_q;

endmodule
